// File: rtl/ex_hazard_ctrl.sv
// Hazard controller for the rv32i five-stage core: shadow scoreboard of EX/MEM/WB
// destinations driving operand forwarding, load-use bubbles, redirect flush and perf counters.
module ex_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_id_ce,
  input  logic [4:0]       i_id_rs1_addr,
  input  logic [4:0]       i_id_rs2_addr,
  input  logic [4:0]       i_id_rd_addr,
  input  logic             i_id_wr_reg,
  input  logic             i_id_load,
  input  logic             i_ex_ce,
  input  logic             i_change_pc,
  input  logic             i_mem_busy,
  input  logic             i_cnt_clr,
  output logic             o_stall_if,
  output logic             o_stall_id,
  output logic             o_force_stall,
  output logic             o_flush,
  output logic [1:0]       o_fwd_rs1_sel,
  output logic [1:0]       o_fwd_rs2_sel,
  output logic             o_state,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam int FCNT_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wr;
    logic       load;
  } slot_t;

  slot_t             ex_q, mem_q, wb_q;
  slot_t             ex_d, mem_d, wb_d;
  state_t            state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic redirect_req;
  logic redirect_acc;
  logic flush;
  logic load_use;
  logic stall;
  logic id_accept;

  function automatic logic hit(input slot_t s, input logic [4:0] rs);
    return s.valid & s.wr & (s.rd == rs) & (rs != 5'd0);
  endfunction

  // Youngest producer wins: EX shadows MEM, MEM shadows WB.
  function automatic logic [1:0] fwd_sel(input slot_t ex, input slot_t mem,
                                         input slot_t wb, input logic [4:0] rs);
    if (hit(ex, rs))       return 2'd1;
    else if (hit(mem, rs)) return 2'd2;
    else if (hit(wb, rs))  return 2'd3;
    else                   return 2'd0;
  endfunction

  // Stall and flush are masked while reset is held so outputs read 0 during reset.
  always_comb begin
    redirect_req = (state_q == RUN) & i_change_pc & i_ex_ce;
    redirect_acc = redirect_req & ~i_mem_busy;
    flush        = reset & ((state_q == FLUSH) | redirect_req);
    load_use     = reset & i_id_ce & ex_q.load & ~flush &
                   (hit(ex_q, i_id_rs1_addr) | hit(ex_q, i_id_rs2_addr));
    stall        = load_use | (reset & i_mem_busy);
    id_accept    = i_id_ce & ~stall & ~flush;
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!i_mem_busy) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      ex_d  = '0;
      if (id_accept) begin
        ex_d.valid = 1'b1;
        ex_d.rd    = i_id_rd_addr;
        ex_d.wr    = i_id_wr_reg;
        ex_d.load  = i_id_load;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (!i_mem_busy) begin
      unique case (state_q)
        RUN: begin
          if (redirect_acc && (FLUSH_CYCLES > 1)) begin
            state_d = FLUSH;
            fcnt_d  = FCNT_W'(FLUSH_CYCLES - 2);
          end
        end
        FLUSH: begin
          if (fcnt_q == '0) state_d = RUN;
          else              fcnt_d  = fcnt_q - FCNT_W'(1);
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (i_cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall)        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (redirect_acc) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      state_q     <= RUN;
      fcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    o_stall_if    = stall;
    o_stall_id    = stall;
    o_force_stall = stall;
    o_flush       = flush;
    o_fwd_rs1_sel = fwd_sel(ex_q, mem_q, wb_q, i_id_rs1_addr);
    o_fwd_rs2_sel = fwd_sel(ex_q, mem_q, wb_q, i_id_rs2_addr);
    o_state       = (state_q == FLUSH);
    o_stall_cnt   = stall_cnt_q;
    o_flush_cnt   = flush_cnt_q;
  end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl: an in-flight instruction list plus a remaining-flush
// counter predicts every output each cycle; literal checks pin the key scenarios.
module tb_ex_hazard_ctrl;

  localparam int FC = 2;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_id_ce = 1'b0;
  logic [4:0]    i_id_rs1_addr = '0;
  logic [4:0]    i_id_rs2_addr = '0;
  logic [4:0]    i_id_rd_addr = '0;
  logic          i_id_wr_reg = 1'b0;
  logic          i_id_load = 1'b0;
  logic          i_ex_ce = 1'b0;
  logic          i_change_pc = 1'b0;
  logic          i_mem_busy = 1'b0;
  logic          i_cnt_clr = 1'b0;
  logic          o_stall_if, o_stall_id, o_force_stall, o_flush, o_state;
  logic [1:0]    o_fwd_rs1_sel, o_fwd_rs2_sel;
  logic [CW-1:0] o_stall_cnt, o_flush_cnt;

  ex_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .i_id_ce(i_id_ce), .i_id_rs1_addr(i_id_rs1_addr), .i_id_rs2_addr(i_id_rs2_addr),
    .i_id_rd_addr(i_id_rd_addr), .i_id_wr_reg(i_id_wr_reg), .i_id_load(i_id_load),
    .i_ex_ce(i_ex_ce), .i_change_pc(i_change_pc), .i_mem_busy(i_mem_busy),
    .i_cnt_clr(i_cnt_clr),
    .o_stall_if(o_stall_if), .o_stall_id(o_stall_id), .o_force_stall(o_force_stall),
    .o_flush(o_flush), .o_fwd_rs1_sel(o_fwd_rs1_sel), .o_fwd_rs2_sel(o_fwd_rs2_sel),
    .o_state(o_state), .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: list of instructions in flight (index 0 = youngest) and cycles of flush left.
  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       wr;
    bit       ld;
  } rec_t;

  rec_t          pipe[3];
  int            flush_left;
  bit [CW-1:0]   m_sc, m_fc;

  function automatic int producer(input logic [4:0] rs);
    if (rs == 5'd0) return 0;
    for (int i = 0; i < 3; i++)
      if (pipe[i].v && pipe[i].wr && pipe[i].rd == rs) return i + 1;
    return 0;
  endfunction

  function automatic bit m_flush();
    if (!reset) return 1'b0;
    return (flush_left > 0) || (i_change_pc && i_ex_ce);
  endfunction

  function automatic bit m_load_use();
    if (!reset || !i_id_ce || m_flush()) return 1'b0;
    return pipe[0].ld && (producer(i_id_rs1_addr) == 1 || producer(i_id_rs2_addr) == 1);
  endfunction

  function automatic bit m_stall();
    return m_load_use() || (reset && i_mem_busy);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0};
      flush_left = 0;
      m_sc = '0;
      m_fc = '0;
    end else begin
      bit stl, fl, redir, acc;
      stl   = m_stall();
      fl    = m_flush();
      redir = (flush_left == 0) && i_change_pc && i_ex_ce && !i_mem_busy;
      acc   = i_id_ce && !stl && !fl;
      if (i_cnt_clr) begin
        m_sc = '0;
        m_fc = '0;
      end else begin
        if (stl)   m_sc = m_sc + 1;
        if (redir) m_fc = m_fc + 1;
      end
      if (!i_mem_busy) begin
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = acc ? '{1, i_id_rd_addr, i_id_wr_reg, i_id_load} : '{0, 0, 0, 0};
        if (flush_left > 0)  flush_left = flush_left - 1;
        else if (redir)      flush_left = FC - 1;
      end
    end
  end

  always @(negedge clk) begin
    check("stall_if", 32'(o_stall_if), 32'(m_stall()));
    check("stall_id", 32'(o_stall_id), 32'(m_stall()));
    check("force_stall", 32'(o_force_stall), 32'(m_stall()));
    check("flush", 32'(o_flush), 32'(m_flush()));
    check("state", 32'(o_state), 32'(reset && flush_left > 0));
    check("stall_cnt", o_stall_cnt, m_sc);
    check("flush_cnt", o_flush_cnt, m_fc);
    if ((i_id_ce && !m_load_use()) || !reset) begin
      check("rs1_sel", 32'(o_fwd_rs1_sel), reset ? 32'(producer(i_id_rs1_addr)) : 32'd0);
      check("rs2_sel", 32'(o_fwd_rs2_sel), reset ? 32'(producer(i_id_rs2_addr)) : 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic id(input bit ce, input bit [4:0] rs1, input bit [4:0] rs2,
                    input bit [4:0] rd, input bit wr, input bit ld);
    i_id_ce = ce; i_id_rs1_addr = rs1; i_id_rs2_addr = rs2;
    i_id_rd_addr = rd; i_id_wr_reg = wr; i_id_load = ld;
  endtask

  task automatic idle(input int n);
    id(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // reset held with active-looking inputs: everything must read 0
    i_mem_busy = 1; i_change_pc = 1; i_ex_ce = 1;
    mid();
    check("rst_flush", 32'(o_flush), 0);
    check("rst_stall", 32'(o_stall_id), 0);
    check("rst_force", 32'(o_force_stall), 0);
    tick();
    reset = 1; i_mem_busy = 0; i_change_pc = 0;
    idle(2);

    // back-to-back forwarding of x5: EX -> MEM -> WB -> regfile
    id(1, 1, 2, 5, 1, 0); tick();
    id(1, 5, 0, 6, 1, 0); mid();
    check("b2b_ex_sel", 32'(o_fwd_rs1_sel), 1);
    check("b2b_nostall", 32'(o_stall_id), 0);
    tick(); id(1, 5, 0, 0, 0, 0); mid();
    check("b2b_mem_sel", 32'(o_fwd_rs1_sel), 2);
    tick(); mid();
    check("b2b_wb_sel", 32'(o_fwd_rs1_sel), 3);
    tick(); mid();
    check("b2b_rf_sel", 32'(o_fwd_rs1_sel), 0);
    tick(); idle(3);

    // load-use on rs2 = x7: one bubble, then forward from MEM
    id(1, 0, 0, 7, 1, 1); tick();
    id(1, 3, 7, 8, 1, 0); mid();
    check("lu_stall_id", 32'(o_stall_id), 1);
    check("lu_stall_if", 32'(o_stall_if), 1);
    check("lu_force", 32'(o_force_stall), 1);
    tick(); mid();
    check("lu_after_stall", 32'(o_stall_id), 0);
    check("lu_rs2_sel", 32'(o_fwd_rs2_sel), 2);
    check("lu_stall_cnt", o_stall_cnt, 1);
    tick(); idle(3);

    // x0 is never forwarded, even behind a load writing x0
    id(1, 0, 0, 0, 1, 1); tick();
    id(1, 0, 0, 4, 1, 0); mid();
    check("x0_rs1_sel", 32'(o_fwd_rs1_sel), 0);
    check("x0_stall", 32'(o_stall_id), 0);
    tick(); idle(3);

    // redirect at T; repeated change_pc at T+1 ignored; no EX insert while flushing
    i_ex_ce = 1; i_change_pc = 1; id(1, 0, 0, 9, 1, 0); mid();
    check("rd_T_flush", 32'(o_flush), 1);
    check("rd_T_state", 32'(o_state), 0);
    tick(); mid();
    check("rd_T1_flush", 32'(o_flush), 1);
    check("rd_T1_state", 32'(o_state), 1);
    check("rd_T1_fcnt", o_flush_cnt, 1);
    tick(); i_change_pc = 0; id(1, 9, 9, 0, 0, 0); mid();
    check("rd_T2_flush", 32'(o_flush), 0);
    check("rd_T2_state", 32'(o_state), 0);
    check("rd_T2_fcnt", o_flush_cnt, 1);
    check("rd_noinsert", 32'(o_fwd_rs1_sel), 0);
    tick(); idle(3);

    // redirect with a same-cycle load-use, then mem_busy held 3 cycles mid-flush
    id(1, 0, 0, 10, 1, 1); tick();
    id(1, 10, 0, 11, 1, 0); i_change_pc = 1; mid();
    check("fl_lu_flush", 32'(o_flush), 1);
    check("fl_lu_nostall", 32'(o_stall_id), 0);
    tick(); i_change_pc = 0; i_mem_busy = 1; mid();
    check("busy_state", 32'(o_state), 1);
    check("busy_stall", 32'(o_stall_id), 1);
    tick(); tick(); tick(); i_mem_busy = 0; mid();
    check("busy_held_state", 32'(o_state), 1);
    check("busy_held_flush", 32'(o_flush), 1);
    check("busy_stall_cnt", o_stall_cnt, 4);
    check("busy_flush_cnt", o_flush_cnt, 2);
    tick(); mid();
    check("busy_end_state", 32'(o_state), 0);
    check("busy_end_flush", 32'(o_flush), 0);
    tick(); idle(3);

    // async reset asserted mid-FLUSH with nonzero counters
    i_change_pc = 1; tick();
    i_change_pc = 0; mid();
    check("pre_rst_state", 32'(o_state), 1);
    check("pre_rst_fcnt", o_flush_cnt, 3);
    #2;
    reset = 0; i_mem_busy = 1; i_change_pc = 1;
    #1;
    check("mrst_state", 32'(o_state), 0);
    check("mrst_flush", 32'(o_flush), 0);
    check("mrst_stall", 32'(o_stall_if), 0);
    check("mrst_scnt", o_stall_cnt, 0);
    check("mrst_fcnt", o_flush_cnt, 0);
    tick();
    reset = 1; i_mem_busy = 0; i_change_pc = 0; i_ex_ce = 0;
    idle(2);

    // counter clear wins over a same-cycle stall
    i_mem_busy = 1; tick();
    i_cnt_clr = 1; mid();
    check("clr_pre_cnt", o_stall_cnt, 1);
    tick(); i_mem_busy = 0; i_cnt_clr = 0; mid();
    check("clr_cnt", o_stall_cnt, 0);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
